// File: rtl/regfile_debug_arbiter.sv
// Shares the register file X read port and W write port between the CPU pipeline
// (priority) and a debug access unit, forcing a one-cycle stall if debug starves.
module regfile_debug_arbiter #(
    parameter int W_DATA       = 32,
    parameter int W_ADDR       = 5,
    parameter int STARVE_LIMIT = 8,
    parameter int W_CNT        = 4
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              PipeEnX,
    input  logic              PipeEnY,
    input  logic              PipeEnW,
    input  logic [W_ADDR-1:0] PipeAddrX,
    input  logic [W_ADDR-1:0] PipeAddrY,
    input  logic [W_ADDR-1:0] PipeAddrW,
    input  logic [W_DATA-1:0] PipeDataW,
    output logic              PipeStall,
    input  logic              DbgReq,
    input  logic              DbgWrite,
    input  logic [W_ADDR-1:0] DbgAddr,
    input  logic [W_DATA-1:0] DbgWData,
    output logic              DbgAck,
    output logic [W_DATA-1:0] DbgRData,
    output logic              RfEnX,
    output logic              RfEnY,
    output logic              RfEnW,
    output logic [W_ADDR-1:0] RfAddrX,
    output logic [W_ADDR-1:0] RfAddrY,
    output logic [W_ADDR-1:0] RfAddrW,
    output logic [W_DATA-1:0] RfDataW,
    input  logic [W_DATA-1:0] RfDataX
);

    typedef enum logic [1:0] {IDLE, WAIT, RDATA, ACK} state_t;

    localparam logic [W_ADDR-1:0] ZERO_REG  = W_ADDR'(31);
    localparam logic [W_CNT-1:0]  CNT_LAST  = W_CNT'(STARVE_LIMIT - 1);
    localparam logic [W_CNT-1:0]  CNT_MAX   = '1;

    state_t              state, state_nxt;
    logic                op_write;
    logic [W_ADDR-1:0]   op_addr;
    logic [W_DATA-1:0]   op_wdata;
    logic [W_CNT-1:0]    cnt;
    logic                port_busy;
    logic                grant;

    assign port_busy = op_write ? PipeEnW : PipeEnX;
    // A registered stall guarantees the target port is ours this cycle.
    assign grant     = (state == WAIT) && (!port_busy || PipeStall);
    assign DbgAck    = (state == ACK);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (DbgReq) state_nxt = WAIT;
            WAIT:    if (grant) state_nxt = op_write ? ACK : RDATA;
            RDATA:   state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            op_write  <= 1'b0;
            op_addr   <= '0;
            op_wdata  <= '0;
            cnt       <= '0;
            PipeStall <= 1'b0;
            DbgRData  <= '0;
        end else begin
            case (state)
                IDLE: if (DbgReq) begin
                    op_write <= DbgWrite;
                    op_addr  <= DbgAddr;
                    op_wdata <= DbgWData;
                    cnt      <= '0;
                end
                WAIT: if (grant) begin
                    cnt       <= '0;
                    PipeStall <= 1'b0;
                end else begin
                    if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) PipeStall <= 1'b1;
                end
                RDATA: DbgRData <= (op_addr == ZERO_REG) ? '0 : RfDataX;
                default: ;
            endcase
        end
    end

    // Pipeline passes through unless stalled; the debug grant overrides its target port.
    always_comb begin
        RfEnX   = PipeEnX & ~PipeStall;
        RfEnY   = PipeEnY & ~PipeStall;
        RfEnW   = PipeEnW & ~PipeStall;
        RfAddrX = PipeAddrX;
        RfAddrY = PipeAddrY;
        RfAddrW = PipeAddrW;
        RfDataW = PipeDataW;
        if (grant) begin
            if (op_write) begin
                RfEnW   = 1'b1;
                RfAddrW = op_addr;
                RfDataW = op_wdata;
            end else begin
                RfEnX   = 1'b1;
                RfAddrX = op_addr;
            end
        end
    end

endmodule

// File: tb/tb_regfile_debug_arbiter.sv
// Directed bench for regfile_debug_arbiter: a transaction-level model predicts grant,
// stall and ack cycles per request; a register-file model supplies read data.
module tb_regfile_debug_arbiter;

    localparam int LIMIT = 8;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        PipeEnX, PipeEnY, PipeEnW;
    logic [4:0]  PipeAddrX, PipeAddrY, PipeAddrW;
    logic [31:0] PipeDataW;
    logic        PipeStall;
    logic        DbgReq, DbgWrite;
    logic [4:0]  DbgAddr;
    logic [31:0] DbgWData;
    logic        DbgAck;
    logic [31:0] DbgRData;
    logic        RfEnX, RfEnY, RfEnW;
    logic [4:0]  RfAddrX, RfAddrY, RfAddrW;
    logic [31:0] RfDataW;
    logic [31:0] RfDataX;

    regfile_debug_arbiter #(.W_DATA(32), .W_ADDR(5), .STARVE_LIMIT(LIMIT), .W_CNT(4)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .PipeEnX(PipeEnX), .PipeEnY(PipeEnY), .PipeEnW(PipeEnW),
        .PipeAddrX(PipeAddrX), .PipeAddrY(PipeAddrY), .PipeAddrW(PipeAddrW),
        .PipeDataW(PipeDataW), .PipeStall(PipeStall),
        .DbgReq(DbgReq), .DbgWrite(DbgWrite), .DbgAddr(DbgAddr), .DbgWData(DbgWData),
        .DbgAck(DbgAck), .DbgRData(DbgRData),
        .RfEnX(RfEnX), .RfEnY(RfEnY), .RfEnW(RfEnW),
        .RfAddrX(RfAddrX), .RfAddrY(RfAddrY), .RfAddrW(RfAddrW),
        .RfDataW(RfDataW), .RfDataX(RfDataX)
    );

    always #5 Clock = ~Clock;

    // Register file: registered read, R31 reads zero, write-through on same-cycle write.
    logic [31:0] rf [32];
    initial for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    always @(posedge Clock) begin
        if (RfEnX)
            RfDataX <= (RfAddrX == 5'd31) ? 32'h0 :
                       (RfEnW && RfAddrW == RfAddrX) ? RfDataW : rf[RfAddrX];
        if (RfEnW && RfAddrW != 5'd31) rf[RfAddrW] <= RfDataW;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model expectations for the current cycle, checked on the falling edge.
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_ack, exp_enx, exp_eny, exp_enw;
    logic [4:0]  exp_addrx, exp_addry, exp_addrw;
    logic [31:0] exp_dataw, exp_rdata;
    logic [31:0] rd_hold = 32'h0;

    always @(negedge Clock) begin
        if (chk_en) begin
            check("stall", 32'(PipeStall), 32'(exp_stall));
            check("ack",   32'(DbgAck),    32'(exp_ack));
            check("rdata", DbgRData,       exp_rdata);
            check("en_x",  32'(RfEnX),     32'(exp_enx));
            check("en_y",  32'(RfEnY),     32'(exp_eny));
            check("en_w",  32'(RfEnW),     32'(exp_enw));
            if (exp_enx) check("addr_x", 32'(RfAddrX), 32'(exp_addrx));
            if (exp_eny) check("addr_y", 32'(RfAddrY), 32'(exp_addry));
            if (exp_enw) begin
                check("addr_w", 32'(RfAddrW), 32'(exp_addrw));
                check("data_w", RfDataW, exp_dataw);
            end
        end
    end

    task automatic idle_inputs();
        PipeEnX = 0; PipeEnY = 0; PipeEnW = 0;
        PipeAddrX = 0; PipeAddrY = 0; PipeAddrW = 0; PipeDataW = 0;
        DbgReq = 0; DbgWrite = 0; DbgAddr = 0; DbgWData = 0;
    endtask

    // One debug transaction. Masks give pipeline port enables per cycle (bit c = cycle c);
    // cycle 0 is the first cycle DbgReq is seen in IDLE.
    task automatic run_case(input string nm, input bit wr, input logic [4:0] addr,
                            input logic [31:0] wd, input logic [31:0] px, input logic [31:0] py,
                            input logic [31:0] pw, input logic [4:0] pa, input logic [31:0] pd,
                            input logic [31:0] rexp, input int ack_lit);
        logic [31:0] busy;
        int g, st, ack, seen;
        bit stall_c;
        busy = wr ? pw : px;
        g = -1; st = -1; seen = -1;
        for (int c = 1; c <= LIMIT; c++) if (g < 0 && !busy[c]) g = c;
        if (g < 0) begin g = LIMIT + 1; st = g; end
        ack = g + (wr ? 1 : 2);
        check({nm, "_model_ack"}, 32'(ack), 32'(ack_lit));
        for (int c = 0; c <= ack + 1; c++) begin
            PipeEnX = px[c]; PipeEnY = py[c]; PipeEnW = pw[c];
            PipeAddrX = pa; PipeAddrY = pa; PipeAddrW = pa; PipeDataW = pd;
            DbgReq = (c < ack); DbgWrite = wr; DbgAddr = addr; DbgWData = wd;
            stall_c   = (c == st);
            exp_stall = stall_c;
            exp_ack   = (c == ack);
            exp_enx   = stall_c ? 1'b0 : px[c];
            exp_eny   = stall_c ? 1'b0 : py[c];
            exp_enw   = stall_c ? 1'b0 : pw[c];
            exp_addrx = pa; exp_addry = pa; exp_addrw = pa; exp_dataw = pd;
            if (c == g) begin
                if (wr) begin exp_enw = 1'b1; exp_addrw = addr; exp_dataw = wd; end
                else    begin exp_enx = 1'b1; exp_addrx = addr; end
            end
            exp_rdata = (!wr && c >= ack) ? rexp : rd_hold;
            chk_en = 1'b1;
            @(negedge Clock);
            if (DbgAck && seen < 0) seen = c;
            @(posedge Clock); #1;
        end
        chk_en = 1'b0;
        if (!wr) rd_hold = rexp;
        check({nm, "_dut_ack_cycle"}, 32'(seen), 32'(ack_lit));
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        Reset_n = 1'b0;
        repeat (2) @(posedge Clock);
        #2;
        check("reset_stall", 32'(PipeStall), 32'h0);
        check("reset_ack",   32'(DbgAck),    32'h0);
        check("reset_rdata", DbgRData,       32'h0);
        Reset_n = 1'b1;
        @(posedge Clock); #1;

        //        name      wr addr   wdata          px            py            pw            pa     pd            rexp          ack
        run_case("wr_r5",   1, 5'd5,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        5'd0,  32'h0,        32'h0,        2);
        run_case("rd_r5",   0, 5'd5,  32'h0,        32'h0,        32'h0,        32'h0,        5'd0,  32'h0,        32'hDEADBEEF, 3);
        run_case("wr_starve",1,5'd3,  32'h1,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'h77,       32'h0,        10);
        run_case("wr_r7",   1, 5'd7,  32'h12345678, 32'h0,        32'h0,        32'h0,        5'd0,  32'h0,        32'h0,        2);
        run_case("rd_r7_busy",0,5'd7, 32'h0,        32'h0000000F, 32'h0,        32'h0,        5'd2,  32'h0,        32'h12345678, 6);
        run_case("rd_starve",0,5'd5,  32'h0,        32'hFFFFFFFF, 32'h0,        32'h0,        5'd4,  32'h0,        32'hDEADBEEF, 11);
        run_case("wr_r31",  1, 5'd31, 32'h55,       32'h0,        32'h0,        32'h0,        5'd0,  32'h0,        32'h0,        2);
        run_case("rd_r31",  0, 5'd31, 32'h0,        32'h0,        32'h0,        32'h0,        5'd0,  32'h0,        32'h0,        3);
        run_case("rd_r9_wt",0, 5'd9,  32'h0,        32'h0,        32'h0,        32'h00000002, 5'd9,  32'hA5A5A5A5, 32'hA5A5A5A5, 3);

        // Reset while the forced stall is up aborts the request.
        PipeEnW = 1; PipeAddrW = 5'd12; PipeDataW = 32'h99;
        DbgReq = 1; DbgWrite = 1; DbgAddr = 5'd3; DbgWData = 32'hCAFE;
        repeat (LIMIT + 1) begin @(posedge Clock); #1; end
        check("abort_stall_up", 32'(PipeStall), 32'h1);
        #2 Reset_n = 1'b0;
        #1;
        check("abort_stall", 32'(PipeStall), 32'h0);
        check("abort_ack",   32'(DbgAck),    32'h0);
        check("abort_addrw", 32'(RfAddrW),   32'd12);
        idle_inputs();
        #3 Reset_n = 1'b1;
        repeat (4) begin
            @(negedge Clock);
            check("post_abort_enw", 32'(RfEnW),  32'h0);
            check("post_abort_enx", 32'(RfEnX),  32'h0);
            check("post_abort_ack", 32'(DbgAck), 32'h0);
        end
        check("abort_r3_untouched", rf[3], 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
